// File: rtl/icache_pkg.sv
// Shared constants and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    localparam int unsigned LINE_W         = 128;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 4;

    function automatic int unsigned idx_w(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    // Two low address bits select the word inside a line.
    function automatic int unsigned tag_w(input int unsigned num_lines, input int unsigned addr_w);
        return addr_w - 2 - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-port and line-fill bus of the instruction cache; slave = cache view.
interface icache_direct_if
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W = 30
);
    logic                proc_read;
    logic                proc_write;
    logic [ADDR_W-1:0]   proc_addr;
    logic [WORD_W-1:0]   proc_wdata;
    logic [WORD_W-1:0]   proc_rdata;
    logic                proc_stall;

    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-3:0]   mem_addr;
    logic [LINE_W-1:0]   mem_wdata;
    logic [LINE_W-1:0]   mem_rdata;
    logic                mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: asynchronous read, single synchronous write port.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned TAG_W     = 25
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, one 128-bit line fill per miss.
module icache_direct
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned ADDR_W    = 30
) (
    input  logic            clk,
    input  logic            rst,
    icache_direct_if.slave  bus
);

    localparam int unsigned IDX_W = idx_w(NUM_LINES);
    localparam int unsigned TAG_W = tag_w(NUM_LINES, ADDR_W);
    localparam int unsigned LA_W  = ADDR_W - 2;

    logic [0:0]        state_q, state_d;
    logic [LA_W-1:0]   miss_addr_q, miss_addr_d;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_data;
    logic              hit;
    logic              fill_we;

    assign req_idx = bus.proc_addr[IDX_W+1:2];
    assign req_tag = bus.proc_addr[ADDR_W-1:IDX_W+2];

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk        (clk),
        .clr_i      (rst),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_we),
        .wr_idx_i   (miss_addr_q[IDX_W-1:0]),
        .wr_tag_i   (miss_addr_q[LA_W-1:IDX_W]),
        .wr_data_i  (bus.mem_rdata)
    );

    assign hit = bus.proc_read & rd_valid & (rd_tag == req_tag);

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_we     = 1'b0;
        if (state_q == IDLE) begin
            if (bus.proc_read && !hit) begin
                miss_addr_d = bus.proc_addr[ADDR_W-1:2];
                state_d     = FILL;
            end
        end else begin
            // The fill always lands in the latched index, even if the fetch address moved on.
            if (bus.mem_ready) begin
                fill_we = ~rst;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    assign bus.proc_rdata = rd_data[{bus.proc_addr[1:0], 5'd0} +: WORD_W];
    assign bus.proc_stall = ~rst & bus.proc_read & ((state_q == FILL) | ~hit);

    assign bus.mem_read  = (state_q == FILL);
    assign bus.mem_addr  = miss_addr_q;
    assign bus.mem_write = 1'b0;
    assign bus.mem_wdata = '0;

    logic unused_inputs;
    assign unused_inputs = ^{bus.proc_write, bus.proc_wdata};

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: misses, hits, conflicts, redirect, reset and write handling.
module tb_icache_direct;

    logic clk;
    logic rst;

    icache_direct_if #(.ADDR_W(30)) bus ();

    icache_direct #(
        .NUM_LINES (8),
        .ADDR_W    (30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Memory responder state: answers on the mem_lat-th cycle that mem_read is seen.
    int          mem_lat;
    bit          mem_auto;
    int          mem_cnt;
    int          fills_done;
    logic [27:0] fill_log [$];

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        logic [31:0] base;
        base = 32'h5000_0000 + {la, 4'h0};
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // Called just after inputs are driven at the negative edge.
    task automatic mem_step();
        #1;
        if (mem_auto && bus.mem_read) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_line(bus.mem_addr);
                fill_log.push_back(bus.mem_addr);
                fills_done++;
                mem_cnt = 0;
            end else begin
                bus.mem_ready = 1'b0;
            end
        end else begin
            bus.mem_ready = 1'b0;
            mem_cnt = 0;
        end
        #1;
    endtask

    // Holds a fetch of addr until stall drops; stalls = -1 on timeout.
    task automatic run_fetch(input logic [29:0] addr, output int stalls, output logic [31:0] data);
        stalls = -1;
        data   = 'x;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            bus.proc_read  = 1'b1;
            bus.proc_write = 1'b0;
            bus.proc_addr  = addr;
            mem_step();
            if (!bus.proc_stall) begin
                stalls = c;
                data   = bus.proc_rdata;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.proc_read = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h04;
        @(negedge clk);
        #1;
        tests++;
        if (bus.proc_stall !== 1'b0) begin
            fails++; $display("FAIL reset_stall: got %b want 0", bus.proc_stall);
        end
        tests++;
        if (bus.mem_read !== 1'b0) begin
            fails++; $display("FAIL reset_mem_read: got %b want 0", bus.mem_read);
        end
        tests++;
        if (bus.mem_addr !== 28'h0) begin
            fails++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.proc_read = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        #1;
        tests++;
        if (bus.proc_stall !== 1'b0) begin
            fails++; $display("FAIL idle_noread_stall: got %b want 0", bus.proc_stall);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        tests++;
        if (bus.mem_read !== 1'b0) begin
            fails++; $display("FAIL idle_ready_ignored: mem_read got %b want 0", bus.mem_read);
        end
    endtask

    task automatic test_cold_miss();
        int          st;
        logic [31:0] d;
        int          f0;
        f0 = fills_done;
        run_fetch(30'h04, st, d);
        tests++;
        if (st !== 6) begin
            fails++; $display("FAIL cold_miss_stalls: got %0d want 6", st);
        end
        tests++;
        if (d !== 32'h5000_0010) begin
            fails++; $display("FAIL cold_miss_rdata: got %h want 50000010", d);
        end
        tests++;
        if (fills_done - f0 !== 1 || fill_log[fill_log.size()-1] !== 28'h1) begin
            fails++; $display("FAIL cold_miss_mem_addr: fills %0d addr %h want 1 fill at 0000001",
                              fills_done - f0, fill_log[fill_log.size()-1]);
        end
    endtask

    task automatic test_line_hits();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h5000_0011;
        exp_w[1] = 32'h5000_0012;
        exp_w[2] = 32'h5000_0013;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.proc_read = 1'b1;
            bus.proc_addr = 30'h05 + 30'(i);
            mem_step();
            tests++;
            if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0) begin
                fails++; $display("FAIL hit_stall[%0d]: stall %b mem_read %b want 0 0",
                                  i, bus.proc_stall, bus.mem_read);
            end
            tests++;
            if (bus.proc_rdata !== exp_w[i]) begin
                fails++; $display("FAIL hit_rdata[%0d]: got %h want %h", i, bus.proc_rdata, exp_w[i]);
            end
        end
    endtask

    task automatic test_write_ignored();
        int          st;
        logic [31:0] d;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.proc_read  = 1'b0;
            bus.proc_write = 1'b1;
            bus.proc_addr  = 30'h05;
            bus.proc_wdata = 32'hDEAD_BEEF;
            mem_step();
            tests++;
            if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0) begin
                fails++; $display("FAIL write_stall[%0d]: stall %b mem_read %b want 0 0",
                                  i, bus.proc_stall, bus.mem_read);
            end
        end
        run_fetch(30'h05, st, d);
        tests++;
        if (st !== 0 || d !== 32'h5000_0011) begin
            fails++; $display("FAIL write_readback: stalls %0d rdata %h want 0 50000011", st, d);
        end
    endtask

    task automatic test_conflict();
        logic [29:0] addrs [3];
        logic [31:0] exp_d [3];
        logic [27:0] exp_a [3];
        int          st;
        logic [31:0] d;
        addrs[0] = 30'h04; exp_d[0] = 32'h5000_0010; exp_a[0] = 28'h1;
        addrs[1] = 30'h24; exp_d[1] = 32'h5000_0090; exp_a[1] = 28'h9;
        addrs[2] = 30'h04; exp_d[2] = 32'h5000_0010; exp_a[2] = 28'h1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_fetch(addrs[i], st, d);
            tests++;
            if (st !== 6 || d !== exp_d[i] || fill_log[fill_log.size()-1] !== exp_a[i]) begin
                fails++; $display("FAIL conflict[%0d]: stalls %0d rdata %h fill %h want 6 %h %h",
                                  i, st, d, fill_log[fill_log.size()-1], exp_d[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_redirect();
        int          st;
        logic [31:0] d;
        int          f0;
        f0 = fills_done;
        @(negedge clk);
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h10;
        mem_step();
        tests++;
        if (bus.proc_stall !== 1'b1) begin
            fails++; $display("FAIL redirect_first_miss: stall %b want 1", bus.proc_stall);
        end
        // From the first FILL cycle onward the fetch address is 0x40.
        run_fetch(30'h40, st, d);
        tests++;
        if (st !== 11 || d !== 32'h5000_0100) begin
            fails++; $display("FAIL redirect_fetch: stalls %0d rdata %h want 11 50000100", st, d);
        end
        tests++;
        if (fills_done - f0 !== 2 || fill_log[fill_log.size()-2] !== 28'h4 ||
            fill_log[fill_log.size()-1] !== 28'h10) begin
            fails++; $display("FAIL redirect_fills: count %0d addrs %h %h want 2 0000004 0000010",
                              fills_done - f0, fill_log[fill_log.size()-2], fill_log[fill_log.size()-1]);
        end
        run_fetch(30'h10, st, d);
        tests++;
        if (st !== 0 || d !== 32'h5000_0040) begin
            fails++; $display("FAIL redirect_reread: stalls %0d rdata %h want 0 50000040", st, d);
        end
    endtask

    task automatic test_reset_mid_fill();
        int          st;
        logic [31:0] d;
        mem_auto = 1'b0;
        @(negedge clk);
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h08;
        bus.mem_ready = 1'b0;
        #1;
        tests++;
        if (bus.proc_stall !== 1'b1) begin
            fails++; $display("FAIL rmf_miss: stall %b want 1", bus.proc_stall);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h2) begin
            fails++; $display("FAIL rmf_fill: mem_read %b mem_addr %h want 1 0000002",
                              bus.mem_read, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (bus.proc_stall !== 1'b0) begin
            fails++; $display("FAIL rmf_stall_in_rst: got %b want 0", bus.proc_stall);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.proc_read = 1'b0;
        #1;
        tests++;
        if (bus.mem_read !== 1'b0) begin
            fails++; $display("FAIL rmf_mem_read_after_rst: got %b want 0", bus.mem_read);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        tests++;
        if (bus.mem_read !== 1'b0) begin
            fails++; $display("FAIL rmf_pulse_ignored: mem_read %b want 0", bus.mem_read);
        end
        mem_auto = 1'b1;
        mem_cnt  = 0;
        run_fetch(30'h08, st, d);
        tests++;
        if (st !== 6 || d !== 32'h5000_0020) begin
            fails++; $display("FAIL rmf_refetch: stalls %0d rdata %h want 6 50000020", st, d);
        end
        run_fetch(30'h10, st, d);
        tests++;
        if (st !== 6 || d !== 32'h5000_0040) begin
            fails++; $display("FAIL rmf_valid_cleared: stalls %0d rdata %h want 6 50000040", st, d);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        mem_lat        = 5;
        mem_auto       = 1'b1;
        mem_cnt        = 0;
        fills_done     = 0;
        rst            = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;

        test_reset();
        test_cold_miss();
        test_line_hits();
        test_write_ignored();
        test_conflict();
        test_redirect();
        test_reset_mid_fill();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
